// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU op constants and the multiply sequencer state type.
// Imported by the alu and the shift-add multiply sequencer.
package alu_mul_sequencer_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'b00,
      MUL_RUN  = 2'b01,
      MUL_DONE = 2'b10
   } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer_alu.sv
// Combinational integer ALU shared by the execute path.
// EQ flags operand equality for branch compare.
module alu
   import alu_mul_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            ALUControl,
   input  logic [DATA_WIDTH-1:0] ALUop1,
   input  logic [DATA_WIDTH-1:0] ALUop2,
   output logic [DATA_WIDTH-1:0] ALUout,
   output logic                  EQ
);

   logic slt;

   assign slt = $signed(ALUop1) < $signed(ALUop2);
   assign EQ  = (ALUop1 == ALUop2);

   always_comb begin
      ALUout = '0;
      case (ALUControl)
         ALU_ADD: ALUout = ALUop1 + ALUop2;
         ALU_SUB: ALUout = ALUop1 - ALUop2;
         ALU_AND: ALUout = ALUop1 & ALUop2;
         ALU_OR:  ALUout = ALUop1 | ALUop2;
         ALU_SLT: ALUout = {{(DATA_WIDTH-1){1'b0}}, slt};
         default: ALUout = '0;
      endcase
   end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add MUL sequencer: low DATA_WIDTH bits of op_a*op_b
// in a fixed DATA_WIDTH-cycle run, reusing the alu adder.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_WIDTH-1:0] LAST =
      CNT_WIDTH'(DATA_WIDTH - 1);

   mul_state_t            state, state_nx;
   logic [DATA_WIDTH-1:0] acc, mcand, mplier;
   logic [DATA_WIDTH-1:0] addend, alu_out;
   logic [CNT_WIDTH-1:0]  count;
   logic                  last;
   logic                  alu_eq_unused;

   assign last   = (count == LAST);
   assign addend = mplier[0] ? mcand : '0;

   alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .ALUControl (ALU_ADD),
      .ALUop1     (acc),
      .ALUop2     (addend),
      .ALUout     (alu_out),
      .EQ         (alu_eq_unused)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= MUL_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         MUL_IDLE: if (start) state_nx = MUL_RUN;
         MUL_RUN:  if (last)  state_nx = MUL_DONE;
         MUL_DONE: state_nx = MUL_IDLE;
         default:  state_nx = MUL_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == MUL_RUN) || (state == MUL_DONE);
      done = (state == MUL_DONE);
   end

   // Final sum is latched on the RUN->DONE edge so it is
   // already visible while done is high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         result <= '0;
      end else begin
         case (state)
            MUL_IDLE: begin
               if (start) begin
                  mcand  <= op_a;
                  mplier <= op_b;
                  acc    <= '0;
                  count  <= '0;
               end
            end
            MUL_RUN: begin
               acc    <= alu_out;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + CNT_WIDTH'(1);
               if (last) result <= alu_out;
            end
            MUL_DONE: result <= acc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: directed
// scenarios plus random operands against a product model.
module tb_alu_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] result;

   int n_chk  = 0;
   int n_fail = 0;

   alu_mul_sequencer #(.DATA_WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(
      input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      return p[31:0];
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   // Issue one op and watch 40 cycles: busy for exactly 33,
   // one done at cycle 33 carrying the model product.
   task automatic do_mul(input logic [31:0] a,
                         input logic [31:0] b,
                         input string tag);
      int ndone = 0;
      int dcyc  = -1;
      int bad_busy = 0;
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (j == 1) begin
            start = 1'b0;
            op_a  = $urandom;
            op_b  = $urandom;
         end
         if (busy !== (j <= 33)) bad_busy++;
         if (done === 1'b1) begin
            ndone++;
            dcyc = j;
            chk({tag, "_result"}, result, model(a, b));
         end
      end
      chk({tag, "_busy_errs"}, 32'(bad_busy), 32'd0);
      chk({tag, "_ndone"}, 32'(ndone), 32'd1);
      chk({tag, "_latency"}, 32'(dcyc), 32'd33);
      chk({tag, "_hold"}, result, model(a, b));
   endtask

   initial begin
      int ndone;
      int bad;
      rst_n = 1'b0; start = 1'b0;
      op_a = '0; op_b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_mul(32'd3, 32'd5, "basic");
      chk("basic_val", result, 32'd15);
      do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, "wrap1");
      chk("wrap1_val", result, 32'h00000001);
      do_mul(32'h00010000, 32'h00010000, "wrap2");
      chk("wrap2_val", result, 32'h00000000);
      do_mul(32'hFFFFFFF9, 32'd6, "signed");
      chk("signed_val", result, 32'hFFFFFFD6);
      do_mul(32'd0, 32'h12345678, "zero");
      chk("zero_val", result, 32'd0);

      // start while busy, including during the DONE cycle
      @(negedge clk);
      start = 1'b1; op_a = 32'd4; op_b = 32'd4;
      ndone = 0;
      for (int j = 1; j <= 45; j++) begin
         @(negedge clk);
         start = (j == 5) || (j == 33);
         op_a  = 32'd9; op_b = 32'd9;
         if (done === 1'b1) begin
            ndone++;
            chk("busy_ign_cycle", 32'(j), 32'd33);
         end
      end
      start = 1'b0;
      chk("busy_ign_ndone", 32'(ndone), 32'd1);
      chk("busy_ign_result", result, 32'd16);
      chk("busy_ign_idle", 32'(busy), 32'd0);
      do_mul(32'd9, 32'd9, "fresh");
      chk("fresh_val", result, 32'd81);

      // reset mid-run discards the op
      @(negedge clk);
      start = 1'b1; op_a = 32'd7; op_b = 32'd7;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", result, 32'd0);
      ndone = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      chk("midrst_quiet", 32'(ndone), 32'd0);
      do_mul(32'd7, 32'd7, "after_rst");
      chk("after_rst_val", result, 32'd49);

      // result hold through a long idle
      do_mul(32'd3, 32'd5, "hold");
      bad = 0;
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         if (result !== 32'd15 || done !== 1'b0) bad++;
      end
      chk("hold_100", 32'(bad), 32'd0);

      for (int k = 0; k < 20; k++) begin
         do_mul($urandom, $urandom, $sformatf("rnd%0d", k));
      end
      do_mul(32'h80000000, 32'd2, "msb_out");
      do_mul(32'd1, 32'h80000001, "ident");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
